// File: rtl/div_16by8_seq.sv
// -----------------------------------------------------------------------------
// div_16by8_seq
// Sequential unsigned 16-by-8 divider, restoring radix-2, one quotient bit per
// clock, MSB first. Works as the inverse of the 8x8 multipliers:
// dividend = quot*divisor + rem with rem < divisor whenever divisor != 0.
// A divide-by-zero skips the iteration and completes on the accepting edge
// with quot = ZERO_QUOT, rem = dividend[7:0], dz = 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; aborts any operation in flight
//   in_valid   operand pair present on dividend/divisor
//   in_ready   high only in IDLE; the block can accept operands
//   dividend   16-bit unsigned dividend
//   divisor    8-bit unsigned divisor
//   out_valid  high only in DONE; quot/rem/dz hold a result
//   out_ready  consumer takes the result; DONE -> IDLE on that edge
//   quot       16-bit registered quotient
//   rem        8-bit registered remainder
//   dz         registered divide-by-zero flag
//
// Timing: the accepting edge loads the operands, 16 CALC edges follow, so
// out_valid rises 17 edges after the transfer counting the accepting edge.
// in_ready returns the cycle after the result is taken, giving a minimum
// initiation interval of 18 cycles.
// -----------------------------------------------------------------------------
module div_16by8_seq #(
  parameter logic [15:0] ZERO_QUOT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  cnt;        // iteration counter, 0..15 during CALC
  logic [7:0]  prem;       // partial remainder; always < divisor, so 8 bits hold it
  logic [15:0] shreg;      // dividend bits shift out at the top, quotient bits in at the bottom
  logic [7:0]  dvs;        // divisor latched at the accepting edge

  logic        accept;
  logic [8:0]  trial;      // 9-bit shifted partial remainder {prem, next dividend bit}
  logic        q_bit;
  logic [7:0]  prem_nxt;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One restoring step. The shifted value can reach 9 bits, which is why the
  // compare is done at 9 bits; after a successful subtract the result is
  // again below the divisor and fits in 8 bits.
  always_comb begin
    trial    = {prem, shreg[15]};
    q_bit    = (trial >= {1'b0, dvs});
    prem_nxt = q_bit ? 8'(trial - {1'b0, dvs}) : trial[7:0];
  end

  // NOTE: every signal written in a combinational block gets a default at the
  // top so that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (divisor == 8'd0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath registers are reset along with the FSM because the
  // outputs must read zero after reset; a plain storage array would not need it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      prem  <= 8'd0;
      shreg <= 16'd0;
      dvs   <= 8'd0;
      quot  <= 16'd0;
      rem   <= 8'd0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == 8'd0) begin
              quot <= ZERO_QUOT;
              rem  <= dividend[7:0];
              dz   <= 1'b1;
            end else begin
              cnt   <= 4'd0;
              prem  <= 8'd0;
              shreg <= dividend;
              dvs   <= divisor;
            end
          end
        end
        CALC: begin
          cnt   <= cnt + 4'd1;
          prem  <= prem_nxt;
          shreg <= {shreg[14:0], q_bit};
          if (cnt == 4'd15) begin
            quot <= {shreg[14:0], q_bit};
            rem  <= prem_nxt;
            dz   <= 1'b0;
          end
        end
        default: begin
          // DONE: results hold until the consumer takes them.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16by8_seq.sv
// -----------------------------------------------------------------------------
// tb_div_16by8_seq
// Directed and randomised stimulus for div_16by8_seq. Inputs are driven and
// outputs sampled on the falling edge; every scenario task does its own
// comparisons against hand-computed values or the / and % operators.
// -----------------------------------------------------------------------------
module tb_div_16by8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        dz;

  int n_cmp = 0;
  int n_bad = 0;

  div_16by8_seq #(.ZERO_QUOT(16'hFFFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands from a falling edge, wait (bounded) for in_ready, let
  // the accepting rising edge pass, then scramble the inputs so any late
  // sampling by the DUT would corrupt the result.
  task automatic accept_op(input logic [15:0] a, input logic [7:0] b, output bit ok);
    int t;
    t        = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Edges counted including the accepting edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (quot !== 16'h0000)   begin n_bad++; $display("FAIL reset_quot got %h want 0000", quot); end
    n_cmp++; if (rem !== 8'h00)       begin n_bad++; $display("FAIL reset_rem got %h want 00", rem); end
    n_cmp++; if (dz !== 1'b0)         begin n_bad++; $display("FAIL reset_dz got %b want 0", dz); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One directed division with hand-computed expectations.
  task automatic run_directed(input string name, input logic [15:0] a, input logic [7:0] b,
                              input logic [15:0] eq, input logic [7:0] er, input logic edz,
                              input int elat);
    bit ok;
    int lat;
    accept_op(a, b, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept in_ready never rose", name); end
    wait_result(lat);
    n_cmp++; if (lat != elat)  begin n_bad++; $display("FAIL %s_latency got %0d want %0d", name, lat, elat); end
    n_cmp++; if (quot !== eq)  begin n_bad++; $display("FAIL %s_quot got %h want %h", name, quot, eq); end
    n_cmp++; if (rem !== er)   begin n_bad++; $display("FAIL %s_rem got %h want %h", name, rem, er); end
    n_cmp++; if (dz !== edz)   begin n_bad++; $display("FAIL %s_dz got %b want %b", name, dz, edz); end
    release_result();
  endtask

  task automatic test_basic();
    run_directed("d1000_7",   16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17);
    run_directed("dffff_1",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17);
    run_directed("d00ff_10",  16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0, 17);
    run_directed("dffff_ff",  16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17);
    run_directed("d0005_09",  16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 17);
  endtask

  task automatic test_div_zero();
    run_directed("dz_1234",   16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1);
    // A normal result after a divide-by-zero must clear dz again.
    run_directed("after_dz",  16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 17);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [15:0] q0;
    logic [7:0]  r0;
    logic        d0;
    bit          stable;
    accept_op(16'h2710, 8'h64, ok);
    wait_result(lat);
    n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL bp_latency got %0d want 17", lat); end
    q0 = quot; r0 = rem; d0 = dz;
    stable = 1'b1;
    in_valid = 1'b1;
    dividend = 16'h1111;
    divisor  = 8'h00;
    repeat (5) begin
      @(negedge clk);
      if (quot !== q0 || rem !== r0 || dz !== d0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++; if (!stable)        begin n_bad++; $display("FAIL bp_hold outputs or handshakes moved under backpressure"); end
    n_cmp++; if (q0 !== 16'h0064) begin n_bad++; $display("FAIL bp_quot got %h want 0064", q0); end
    n_cmp++; if (r0 !== 8'h00)   begin n_bad++; $display("FAIL bp_rem got %h want 00", r0); end
    release_result();
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit saw_valid;
    accept_op(16'hABCD, 8'h13, ok);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_cmp++; if (quot !== 16'h0000 || rem !== 8'h00 || dz !== 1'b0)
      begin n_bad++; $display("FAIL abort_outputs got %h/%h/%b want 0000/00/0", quot, rem, dz); end
    saw_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_valid) begin n_bad++; $display("FAIL abort_no_result got out_valid pulse want none"); end
    run_directed("post_abort", 16'hC350, 8'hC8, 16'h00FA, 8'h00, 1'b0, 17);
  endtask

  // in_valid and out_ready held high: results 18 cycles apart and the
  // operand pair presented during CALC is not taken twice mid-operation.
  task automatic test_back_to_back();
    int first;
    int second;
    int t;
    logic [15:0] q1;
    logic [7:0]  r1;
    first  = -1;
    second = -1;
    q1 = 16'h0;
    r1 = 8'h0;
    in_valid  = 1'b1;
    dividend  = 16'd100;
    divisor   = 8'd3;
    out_ready = 1'b1;
    t = 0;
    while (second < 0 && t < 100) begin
      @(negedge clk);
      t++;
      if (out_valid) begin
        if (first < 0) begin
          first = t;
          q1 = quot;
          r1 = rem;
        end else if (t > first + 1) begin
          second = t;
          in_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (second - first != 18) begin n_bad++; $display("FAIL b2b_interval got %0d want 18", second - first); end
    n_cmp++; if (q1 !== 16'd33) begin n_bad++; $display("FAIL b2b_quot got %0d want 33", q1); end
    n_cmp++; if (r1 !== 8'd1)   begin n_bad++; $display("FAIL b2b_rem got %0d want 1", r1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got in_ready %b want 1", in_ready); end
  endtask

  task automatic test_random(input int n_ops);
    bit ok;
    int lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    for (int i = 0; i < n_ops; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        eq = 16'hFFFF; er = a[7:0]; edz = 1'b1;
      end else begin
        eq = a / {8'd0, b}; er = 8'(a % {8'd0, b}); edz = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept_op(a, b, ok);
      wait_result(lat);
      n_cmp++; if (!ok || lat != (edz ? 1 : 17))
        begin n_bad++; $display("FAIL rnd_latency op %0d got %0d want %0d", i, lat, edz ? 1 : 17); end
      n_cmp++; if (quot !== eq) begin n_bad++; $display("FAIL rnd_quot %h/%h got %h want %h", a, b, quot, eq); end
      n_cmp++; if (rem !== er)  begin n_bad++; $display("FAIL rnd_rem %h/%h got %h want %h", a, b, rem, er); end
      n_cmp++; if (dz !== edz)  begin n_bad++; $display("FAIL rnd_dz %h/%h got %b want %b", a, b, dz, edz); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0;
    divisor   = 8'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random(1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
